// File: rtl/fb_read_arbiter_pkg.sv
// Frame-buffer shared definitions.
// Holds the 320x240 frame geometry (4 packed 4-bit pixels per 16-bit word),
// the default BRAM address/data widths and the fixed requester indices used by
// the read arbiter and its clients. fb_word_addr() maps a pixel coordinate to
// the word that holds it.
package fb_pkg;

  localparam int FB_WIDTH     = 320;
  localparam int FB_HEIGHT    = 240;
  localparam int PIX_PER_WORD = 4;
  localparam int FB_WORDS     = (FB_WIDTH * FB_HEIGHT) / PIX_PER_WORD;  // 19200

  localparam int FB_AW = 15;
  localparam int FB_DW = 16;

  // Requester indices on the arbiter. The display reader must be index 0
  // because that port carries the fixed top priority.
  localparam int REQ_VGA    = 0;
  localparam int REQ_THRESH = 1;
  localparam int REQ_MINMAX = 2;

  function automatic logic [FB_AW-1:0] fb_word_addr(input logic [8:0] x,
                                                    input logic [7:0] y);
    return FB_AW'((int'(y) * FB_WIDTH + int'(x)) / PIX_PER_WORD);
  endfunction

endpackage

// File: rtl/fb_read_arbiter_rr_picker.sv
// rr_picker: combinational round-robin one-hot selector.
// Searches ports REQ_THRESH..NREQ-1 starting at rr_ptr and wrapping from
// NREQ-1 back to REQ_THRESH; the first port with req set is picked. Port 0
// (the display reader) is never considered here, it is handled by the caller.
// Ports:
//   req     in  NREQ  per-port request
//   rr_ptr  in  PW    first port to consider (REQ_THRESH..NREQ-1)
//   pick    out NREQ  one-hot pick, all zero when no port 1..NREQ-1 requests
module rr_picker
  import fb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] pick
);

  localparam int NRR = NREQ - REQ_THRESH;

  // Port 0 is outside the round-robin ring.
  logic unused_req_vga;
  assign unused_req_vga = req[REQ_VGA];

  always_comb begin
    logic          found;
    int            slot;
    logic [PW-1:0] idx;
    pick  = '0;
    found = 1'b0;
    slot  = 0;
    idx   = '0;
    for (int o = 0; o < NRR; o++) begin
      // Ring position o steps away from rr_ptr, folded back into 1..NREQ-1.
      slot = ((int'(rr_ptr) - REQ_THRESH + o) % NRR) + REQ_THRESH;
      idx  = PW'(slot);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_read_arbiter.sv
// fb_read_arbiter: shares the single frame-buffer BRAM read port among NREQ
// requesters. Port 0 (VGA display reader) has fixed top priority; ports
// 1..NREQ-1 share the remaining cycles round-robin. Read data comes back on a
// broadcast rdata bus with a one-hot rvalid tag RD_LAT+1 cycles after the grant.
//
// Handshake: a requester raises req[i] with its address and holds both until
// gnt[i] is seen in the same cycle (gnt is combinational). A grant is a
// committed read: exactly RD_LAT+1 cycles later rvalid[i] is high for one
// cycle with the word on rdata. There is no back-pressure on the return side,
// so a new grant may be issued every cycle.
//
// Optional build macro FB_ARB_STARVE_GUARD_EN: per-port wait counters let a
// port that has waited STARVE_LIMIT cycles win over port 0 for one cycle.
// Without it port 0 strictly pre-empts every other port.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   req        per-requester read request
//   req_addr   flattened addresses, slice i = [i*AW +: AW]
//   gnt        one-hot grant (combinational)
//   rvalid     one-hot return tag
//   rdata      read data, broadcast
//   bram_en    BRAM read enable
//   bram_addr  BRAM read address
//   bram_dout  BRAM read data, RD_LAT cycles after bram_en
//   busy       a read is in flight in the return pipeline
module fb_read_arbiter
  import fb_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int AW           = FB_AW,
  parameter int DW           = FB_DW,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               bram_en,
  output logic [AW-1:0]      bram_addr,
  input  logic [DW-1:0]      bram_dout,
  output logic               busy
);

  localparam int            PW        = $clog2(NREQ);
  localparam logic [PW-1:0] PTR_FIRST = PW'(REQ_THRESH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(NREQ - 1);

  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] rr_gnt;
  logic [NREQ-1:0] gnt_arb;
  logic [NREQ-1:0] starve_gnt;
  logic            starve_any;
  logic [PW-1:0]   gnt_idx;

  // Return pipeline: stage 0 is loaded with the grant, the last stage feeds
  // the rvalid/rdata output register.
  logic [RD_LAT-1:0]           pipe_vld;
  logic [RD_LAT-1:0][NREQ-1:0] pipe_id;

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (rr_gnt)
  );

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

  logic [7:0] wait_cnt [REQ_THRESH:NREQ-1];

  // Lowest-index port whose counter has reached the limit and that is still
  // requesting; a port that has just dropped req is not worth a grant.
  always_comb begin
    starve_gnt = '0;
    starve_any = 1'b0;
    for (int i = REQ_THRESH; i < NREQ; i++) begin
      if (!starve_any && req[i] && (wait_cnt[i] >= STARVE_LIM8)) begin
        starve_gnt[i] = 1'b1;
        starve_any    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = REQ_THRESH; i < NREQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = REQ_THRESH; i < NREQ; i++) begin
        if (!req[i] || gnt[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != 8'hFF) begin
          wait_cnt[i] <= wait_cnt[i] + 8'd1;
        end
      end
    end
  end
`else
  logic [7:0] unused_starve_lim;
  assign unused_starve_lim = 8'(STARVE_LIMIT);
  assign starve_gnt        = '0;
  assign starve_any        = 1'b0;
`endif

  // Priority: starvation override (if built), then port 0, then round-robin.
  always_comb begin
    gnt_arb = '0;
    if (starve_any) begin
      gnt_arb = starve_gnt;
    end else if (req[REQ_VGA]) begin
      gnt_arb[REQ_VGA] = 1'b1;
    end else begin
      gnt_arb = rr_gnt;
    end
    gnt = rst ? '0 : gnt_arb;
  end

  assign bram_en = |gnt;

  always_comb begin
    bram_addr = '0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        bram_addr = req_addr[i*AW +: AW];
        gnt_idx   = PW'(i);
      end
    end
  end

  // Round-robin pointer: moves past the port just served; port 0 grants
  // leave it alone so the ring resumes where it stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= PTR_FIRST;
    end else if (bram_en && (gnt_idx >= PTR_FIRST)) begin
      rr_ptr <= (gnt_idx == PTR_LAST) ? PTR_FIRST : gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
      rvalid   <= '0;
      rdata    <= '0;
    end else begin
      pipe_vld[0] <= bram_en;
      pipe_id[0]  <= gnt;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
      // The last stage lines up with bram_dout; register both together so
      // rvalid and rdata change on the same edge.
      rvalid <= pipe_vld[RD_LAT-1] ? pipe_id[RD_LAT-1] : '0;
      if (pipe_vld[RD_LAT-1]) begin
        rdata <= bram_dout;
      end
    end
  end

  assign busy = |pipe_vld;

  gnt_at_most_one: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  gnt_when_req:    assert property (@(posedge clk) disable iff (rst) (|req) |-> $onehot(gnt));

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed bench for fb_read_arbiter (NREQ=3, RD_LAT=1). The driver issues one
// request pattern per cycle, checks the combinational grant/BRAM outputs and
// pushes the expected return into a scoreboard; a negedge monitor pops and
// compares whenever rvalid is non-zero. The BRAM model returns addr ^ 16'hA5A5.
module tb_fb_read_arbiter;
  import fb_pkg::*;

  localparam int NREQ   = 3;
  localparam int AW     = 15;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               bram_en;
  logic [AW-1:0]      bram_addr;
  logic [DW-1:0]      bram_dout = '0;
  logic               busy;

  logic [AW-1:0] addr_tab [NREQ];
  assign req_addr = {addr_tab[2], addr_tab[1], addr_tab[0]};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [NREQ+DW-1:0] exp_q[$];
  int                 exp_cyc_q[$];
  logic [NREQ+DW-1:0] mon_e;
  int                 mon_c;

  fb_read_arbiter #(
    .NREQ         (NREQ),
    .AW           (AW),
    .DW           (DW),
    .RD_LAT       (RD_LAT),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .busy      (busy)
  );

  // Clock / cycle counter / BRAM model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bram_en) bram_dout <= DW'(bram_addr) ^ 16'hA5A5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive req, check grant and BRAM side, queue the return.
  task automatic issue(input logic [NREQ-1:0] r, input logic [NREQ-1:0] exp_g, input bit push);
    logic [AW-1:0] a;
    a   = '0;
    req = r;
    #1;
    for (int i = 0; i < NREQ; i++) if (exp_g[i]) a = addr_tab[i];
    check("gnt", gnt, exp_g);
    check("bram_en", bram_en, |exp_g);
    check("bram_addr", bram_addr, a);
    if (push && exp_g != '0) begin
      exp_q.push_back({exp_g, DW'(a) ^ 16'hA5A5});
      exp_cyc_q.push_back(cyc + RD_LAT + 1);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL rvalid_missing: got none expected return due in cycle %0d (now %0d)",
               exp_cyc_q[0], cyc);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    if (rvalid !== '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rvalid_unexpected: got %b expected 000 (cycle %0d)", rvalid, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("rvalid", rvalid, mon_e[DW +: NREQ]);
        check("rdata", rdata, mon_e[DW-1:0]);
        check("rvalid_cycle", cyc, mon_c);
      end
    end
  end

  initial begin
    int w;
    rst         = 1'b1;
    req         = '0;
    addr_tab[0] = 15'h0100;
    addr_tab[1] = 15'h0011;
    addr_tab[2] = 15'h2222;

    // Reset with all requests pending
    req = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 3'b000);
    check("rst_bram_en", bram_en, 1'b0);
    check("rst_bram_addr", bram_addr, 15'h0);
    check("rst_rvalid", rvalid, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, 16'h0);
    rst = 1'b0;
    issue(3'b111, 3'b001, 1'b1);
    check("busy_in_flight", busy, 1'b1);
    issue(3'b000, 3'b000, 1'b0);
    check("busy_drained", busy, 1'b0);

    // Round-robin between ports 1 and 2
    for (int i = 0; i < 6; i++) issue(3'b110, (i % 2 == 0) ? 3'b010 : 3'b100, 1'b1);
    issue(3'b000, 3'b000, 1'b0);

    // Display priority, then the ring resumes at port 1
    for (int i = 0; i < 4; i++) issue(3'b111, 3'b001, 1'b1);
    issue(3'b110, 3'b010, 1'b1);
    issue(3'b000, 3'b000, 1'b0);

    // Single requester, known address
    addr_tab[1] = 15'h1234;
    issue(3'b010, 3'b010, 1'b1);
    repeat (3) issue(3'b000, 3'b000, 1'b0);

    // Reset mid-read: the port 2 return must never appear
    issue(3'b100, 3'b100, 1'b0);
    rst = 1'b1;
    req = '0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_rvalid", rvalid, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) issue(3'b000, 3'b000, 1'b0);

    // Port 0 against port 2
    for (int i = 0; i < 6; i++) begin
`ifdef FB_ARB_STARVE_GUARD_EN
      issue(3'b101, (i == 4) ? 3'b100 : 3'b001, 1'b1);
`else
      issue(3'b101, 3'b001, 1'b1);
`endif
    end
    issue(3'b000, 3'b000, 1'b0);

    // Drain the scoreboard with a bounded wait
    w = 0;
    while (exp_q.size() > 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_read_arbiter.md
Name: fb_read_arbiter

Overview:
- Shares the single frame-buffer BRAM read port (16-bit word = 4 packed 4-bit pixels, 15-bit word address, 19200 words for 320x240) among NREQ requesters: port 0 = VGA display reader, ports 1..NREQ-1 = adaptive-thresholding engine, min-max builder, etc.
- Port 0 has fixed top priority; the others share the remaining cycles round-robin.
- Sits between the requesters and the frame-buffer BRAM. Read data returns with a per-requester valid tag aligned to the BRAM latency.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 15, word address width.
- DW, 16, data width.
- RD_LAT, 1, BRAM read latency in cycles (1..3).
- STARVE_LIMIT, 64, wait cycles before starvation override (only used with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req  in  NREQ  per-requester read request; held until granted.
- req_addr  in  NREQ*AW  flattened addresses; slice i = [i*AW +: AW].
- gnt  out  NREQ  one-hot grant, combinational, same cycle as req.
- rvalid  out  NREQ  one-hot; data for requester i is on rdata.
- rdata  out  DW  read data, broadcast to all requesters.
- bram_en  out  1  BRAM read enable.
- bram_addr  out  AW  BRAM read address.
- bram_dout  in  DW  BRAM read data, valid RD_LAT cycles after bram_en.
- busy  out  1  a read is in flight in the return pipeline.

Behaviour:
- Reset is asynchronous, active-high. Values held during and after reset:
  - rr_ptr = 1.
  - Return pipeline cleared.
  - rvalid = 0, busy = 0.
  - Starvation counters = 0.
  - rdata = 0.
- gnt, bram_en and bram_addr are combinational. While rst is asserted they are forced to 0.
- Arbitration each cycle, at most one grant:
  - If req[0] = 1, grant port 0.
  - Else grant the first requesting port from rr_ptr upward within 1..NREQ-1, wrapping from NREQ-1 back to 1.
  - No request: gnt = 0 and bram_en = 0.
- bram_en = |gnt. bram_addr = address slice of the granted port, or 0 when there is no grant.
- Round-robin update: after a grant to port k >= 1, rr_ptr <= k+1, wrapping NREQ-1 -> 1. A grant to port 0 leaves rr_ptr unchanged.
- Return pipeline:
  - Shift register of depth RD_LAT carrying {valid, one-hot id}.
  - Stage 0 loads gnt.
  - rvalid = last stage one-hot id.
  - rdata is bram_dout registered alongside, so rvalid and rdata are both asserted/valid exactly RD_LAT+1 cycles after gnt.
- Back-to-back grants are allowed every cycle. Throughput is 1 word/cycle with no bubbles.
- busy = OR of all pipeline valid bits.
- A requester that drops req without a grant is simply not served. No error is flagged.
- Reset mid-read: in-flight returns are discarded; rvalid never asserts for them.
- Simultaneous requests: exactly one gnt bit is set. This is checked by assertion.

Optional Feature:
- Macro: FB_ARB_STARVE_GUARD_EN.
- Defined:
  - Each port i >= 1 has an 8-bit wait counter: it increments while req[i] && !gnt[i], saturating at 255, and clears on gnt[i] or when req is low.
  - When any counter reaches STARVE_LIMIT, that port (lowest index on a tie) wins over port 0 for exactly one cycle. rr_ptr then updates as for a normal grant.
- Undefined: no counters; port 0 strictly pre-empts all other ports.

Decomposition:
- Package fb_pkg holds:
  - FB_WIDTH = 320, FB_HEIGHT = 240.
  - FB_WORDS = 19200.
  - PIX_PER_WORD = 4.
  - AW/DW defaults.
  - The requester index constants REQ_VGA = 0, REQ_THRESH = 1, REQ_MINMAX = 2.
- Sub-module rr_picker: a combinational round-robin one-hot selector over ports 1..NREQ-1, with inputs req and rr_ptr.

Test Plan:
- Reset with requests pending: hold rst = 1 while req = 3'b111 -> gnt = 0, rvalid = 0. Release rst -> first grant gnt = 3'b001.
- Single requester: req = 3'b010, addr1 = 15'h1234, BRAM model returns addr^16'hA5A5 -> bram_addr = 1234 on the same cycle; rvalid = 3'b010 and rdata = 16'hB791 exactly 2 cycles later (RD_LAT = 1).
- Round-robin fairness: req = 3'b110 held for 6 cycles -> grants alternate 010, 100, 010, 100, 010, 100. rvalid follows the same sequence shifted by 2 cycles.
- Display priority: req = 3'b111 for 4 cycles -> gnt = 001 on all 4 cycles, rr_ptr unchanged. Drop req[0] -> next grant is port 1.
- Reset mid-read: grant port 2, assert rst the next cycle -> no rvalid. busy = 0 immediately.
- With FB_ARB_STARVE_GUARD_EN and STARVE_LIMIT = 4: req = 3'b101 held -> port 0 granted for 4 cycles, port 2 on cycle 5, then port 0 again.
